// File: rtl/demultiplexer.sv
// Steers whole Avalon-ST packets from one input to two registered outputs by channel.
// Counts delivered packets per port and discarded orphan beats.
module demultiplexer #(
    parameter int DATA_WIDTH    = 32,
    parameter int EMPTY_WIDTH   = 2,
    parameter int CHANNEL_WIDTH = 1,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [CHANNEL_WIDTH-1:0] avsi_channel,
    input  logic [DATA_WIDTH-1:0]    avsi_data,
    input  logic [EMPTY_WIDTH-1:0]   avsi_empty,
    input  logic                     avsi_valid,
    input  logic                     avsi_sop,
    input  logic                     avsi_eop,
    output logic                     avsi_ready,
    output logic [CHANNEL_WIDTH-1:0] avso_one_channel,
    output logic [DATA_WIDTH-1:0]    avso_one_data,
    output logic [EMPTY_WIDTH-1:0]   avso_one_empty,
    output logic                     avso_one_valid,
    output logic                     avso_one_sop,
    output logic                     avso_one_eop,
    input  logic                     avso_one_ready,
    output logic [CHANNEL_WIDTH-1:0] avso_two_channel,
    output logic [DATA_WIDTH-1:0]    avso_two_data,
    output logic [EMPTY_WIDTH-1:0]   avso_two_empty,
    output logic                     avso_two_valid,
    output logic                     avso_two_sop,
    output logic                     avso_two_eop,
    input  logic                     avso_two_ready,
    output logic [CNT_WIDTH-1:0]     pkt_cnt_one,
    output logic [CNT_WIDTH-1:0]     pkt_cnt_two,
    output logic [CNT_WIDTH-1:0]     drop_cnt,
    output logic                     err_pulse
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] PASS_ONE = 2'd1;
    localparam logic [1:0] PASS_TWO = 2'd2;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       can_one;
    logic       can_two;
    logic       can_both;
    logic       rdy;
    logic       accept;
    logic       route_one;
    logic       route_two;
    logic       orphan;
    logic       mid_sop;
    logic       to_two;

    assign can_one  = ~avso_one_valid | avso_one_ready;
    assign can_two  = ~avso_two_valid | avso_two_ready;
    assign can_both = can_one & can_two;
    assign to_two   = |avsi_channel;

    // A sop may target either port, so it waits until both can take a beat.
    always_comb begin
        rdy = 1'b0;
        case (state)
            PASS_ONE: rdy = can_one & (~avsi_sop | can_both);
            PASS_TWO: rdy = can_two & (~avsi_sop | can_both);
            default:  rdy = can_both;
        endcase
    end

    assign avsi_ready = reset_n & rdy;
    assign accept     = avsi_valid & avsi_ready;

    always_comb begin
        route_one  = 1'b0;
        route_two  = 1'b0;
        orphan     = 1'b0;
        mid_sop    = 1'b0;
        state_next = state;
        if (accept) begin
            if (avsi_sop) begin
                route_one = ~to_two;
                route_two = to_two;
                mid_sop   = (state != IDLE);
                if (avsi_eop)    state_next = IDLE;
                else if (to_two) state_next = PASS_TWO;
                else             state_next = PASS_ONE;
            end else if (state == PASS_ONE) begin
                route_one = 1'b1;
                if (avsi_eop) state_next = IDLE;
            end else if (state == PASS_TWO) begin
                route_two = 1'b1;
                if (avsi_eop) state_next = IDLE;
            end else begin
                orphan     = 1'b1;
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            err_pulse <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            state     <= state_next;
            err_pulse <= orphan | mid_sop;
            if (orphan && drop_cnt != CNT_MAX)
                drop_cnt <= drop_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avso_one_channel <= '0;
            avso_one_data    <= '0;
            avso_one_empty   <= '0;
            avso_one_valid   <= 1'b0;
            avso_one_sop     <= 1'b0;
            avso_one_eop     <= 1'b0;
            pkt_cnt_one      <= '0;
        end else begin
            if (avso_one_valid && avso_one_ready && avso_one_eop)
                pkt_cnt_one <= pkt_cnt_one + CNT_ONE;
            if (route_one) begin
                avso_one_channel <= avsi_channel;
                avso_one_data    <= avsi_data;
                avso_one_empty   <= avsi_empty;
                avso_one_sop     <= avsi_sop;
                avso_one_eop     <= avsi_eop;
                avso_one_valid   <= 1'b1;
            end else if (avso_one_ready) begin
                avso_one_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avso_two_channel <= '0;
            avso_two_data    <= '0;
            avso_two_empty   <= '0;
            avso_two_valid   <= 1'b0;
            avso_two_sop     <= 1'b0;
            avso_two_eop     <= 1'b0;
            pkt_cnt_two      <= '0;
        end else begin
            if (avso_two_valid && avso_two_ready && avso_two_eop)
                pkt_cnt_two <= pkt_cnt_two + CNT_ONE;
            if (route_two) begin
                avso_two_channel <= avsi_channel;
                avso_two_data    <= avsi_data;
                avso_two_empty   <= avsi_empty;
                avso_two_sop     <= avsi_sop;
                avso_two_eop     <= avsi_eop;
                avso_two_valid   <= 1'b1;
            end else if (avso_two_ready) begin
                avso_two_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_demultiplexer.sv
// Directed bench for demultiplexer: per-cycle vector table plus
// hand sequences for counter wrap, drop saturation and mid-packet reset.
module tb_demultiplexer;

    localparam int DW = 32;
    localparam int EW = 2;
    localparam int CW = 1;
    localparam int NW = 4;

    logic          clk;
    logic          reset_n;
    logic [CW-1:0] avsi_channel;
    logic [DW-1:0] avsi_data;
    logic [EW-1:0] avsi_empty;
    logic          avsi_valid;
    logic          avsi_sop;
    logic          avsi_eop;
    logic          avsi_ready;
    logic [CW-1:0] avso_one_channel;
    logic [DW-1:0] avso_one_data;
    logic [EW-1:0] avso_one_empty;
    logic          avso_one_valid;
    logic          avso_one_sop;
    logic          avso_one_eop;
    logic          avso_one_ready;
    logic [CW-1:0] avso_two_channel;
    logic [DW-1:0] avso_two_data;
    logic [EW-1:0] avso_two_empty;
    logic          avso_two_valid;
    logic          avso_two_sop;
    logic          avso_two_eop;
    logic          avso_two_ready;
    logic [NW-1:0] pkt_cnt_one;
    logic [NW-1:0] pkt_cnt_two;
    logic [NW-1:0] drop_cnt;
    logic          err_pulse;

    demultiplexer #(
        .DATA_WIDTH(DW),
        .EMPTY_WIDTH(EW),
        .CHANNEL_WIDTH(CW),
        .CNT_WIDTH(NW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .avsi_channel(avsi_channel),
        .avsi_data(avsi_data),
        .avsi_empty(avsi_empty),
        .avsi_valid(avsi_valid),
        .avsi_sop(avsi_sop),
        .avsi_eop(avsi_eop),
        .avsi_ready(avsi_ready),
        .avso_one_channel(avso_one_channel),
        .avso_one_data(avso_one_data),
        .avso_one_empty(avso_one_empty),
        .avso_one_valid(avso_one_valid),
        .avso_one_sop(avso_one_sop),
        .avso_one_eop(avso_one_eop),
        .avso_one_ready(avso_one_ready),
        .avso_two_channel(avso_two_channel),
        .avso_two_data(avso_two_data),
        .avso_two_empty(avso_two_empty),
        .avso_two_valid(avso_two_valid),
        .avso_two_sop(avso_two_sop),
        .avso_two_eop(avso_two_eop),
        .avso_two_ready(avso_two_ready),
        .pkt_cnt_one(pkt_cnt_one),
        .pkt_cnt_two(pkt_cnt_two),
        .drop_cnt(drop_cnt),
        .err_pulse(err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v, s, e, ch;
        logic [31:0] d;
        logic [1:0]  m;
        logic        r1, r2;
        logic        xr;
        logic        o1v;
        logic [31:0] o1d;
        logic        o1s, o1e;
        logic [1:0]  o1m;
        logic        o2v;
        logic [31:0] o2d;
        logic        o2s, o2e;
        logic [1:0]  o2m;
        logic        xe;
        logic [31:0] c1, c2, dr;
    } vec_t;

    vec_t vq[$];
    int   n_cmp;
    int   n_bad;

    function automatic void add(
        input logic v, s, e, ch,
        input logic [31:0] d, input logic [1:0] m,
        input logic r1, r2, xr,
        input logic o1v, input logic [31:0] o1d,
        input logic o1s, o1e, input logic [1:0] o1m,
        input logic o2v, input logic [31:0] o2d,
        input logic o2s, o2e, input logic [1:0] o2m,
        input logic xe, input logic [31:0] c1, c2, dr);
        vec_t t;
        t.v = v; t.s = s; t.e = e; t.ch = ch; t.d = d; t.m = m;
        t.r1 = r1; t.r2 = r2; t.xr = xr;
        t.o1v = o1v; t.o1d = o1d; t.o1s = o1s; t.o1e = o1e; t.o1m = o1m;
        t.o2v = o2v; t.o2d = o2d; t.o2s = o2s; t.o2e = o2e; t.o2m = o2m;
        t.xe = xe; t.c1 = c1; t.c2 = c2; t.dr = dr;
        vq.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, s, e, ch, input logic [31:0] d,
                         input logic [1:0] m, input logic r1, r2);
        avsi_valid     = v;
        avsi_sop       = s;
        avsi_eop       = e;
        avsi_channel   = ch;
        avsi_data      = d;
        avsi_empty     = m;
        avso_one_ready = r1;
        avso_two_ready = r2;
    endtask

    task automatic cyc(input logic v, s, e, ch, input logic [31:0] d);
        drive(v, s, e, ch, d, 2'd0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ready"}, 32'(avsi_ready), 32'd0);
        chk({tag, " one_valid"}, 32'(avso_one_valid), 32'd0);
        chk({tag, " one_data"}, avso_one_data, 32'd0);
        chk({tag, " one_sop"}, 32'(avso_one_sop), 32'd0);
        chk({tag, " two_valid"}, 32'(avso_two_valid), 32'd0);
        chk({tag, " two_data"}, avso_two_data, 32'd0);
        chk({tag, " cnt_one"}, 32'(pkt_cnt_one), 32'd0);
        chk({tag, " cnt_two"}, 32'(pkt_cnt_two), 32'd0);
        chk({tag, " drop"}, 32'(drop_cnt), 32'd0);
        chk({tag, " err"}, 32'(err_pulse), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 2'd0, 1'b1, 1'b1);

        // basic routing, ch0, 4 beats
        add(1,1,0,0,'h11,0,1,1,1, 1,'h11,1,0,0, 0,0,0,0,0, 0, 0,0,0);
        add(1,0,0,0,'h12,0,1,1,1, 1,'h12,0,0,0, 0,0,0,0,0, 0, 0,0,0);
        add(1,0,0,0,'h13,0,1,1,1, 1,'h13,0,0,0, 0,0,0,0,0, 0, 0,0,0);
        add(1,0,1,0,'h14,2,1,1,1, 1,'h14,0,1,2, 0,0,0,0,0, 0, 0,0,0);
        add(0,0,0,0,0,0,1,1,1,    0,0,0,0,0,    0,0,0,0,0, 0, 1,0,0);
        // back-to-back switch ch0 -> ch1
        add(1,1,0,0,'h21,0,1,1,1, 1,'h21,1,0,0, 0,0,0,0,0, 0, 1,0,0);
        add(1,0,0,0,'h22,0,1,1,1, 1,'h22,0,0,0, 0,0,0,0,0, 0, 1,0,0);
        add(1,0,1,0,'h23,1,1,1,1, 1,'h23,0,1,1, 0,0,0,0,0, 0, 1,0,0);
        add(1,1,0,1,'h31,0,1,1,1, 0,0,0,0,0, 1,'h31,1,0,0, 0, 2,0,0);
        add(1,0,1,1,'h32,3,1,1,1, 0,0,0,0,0, 1,'h32,0,1,3, 0, 2,0,0);
        add(0,0,0,0,0,0,1,1,1,    0,0,0,0,0, 0,0,0,0,0,    0, 2,1,0);
        // backpressure on two for 5 cycles
        add(1,1,0,1,'h41,0,1,1,1, 0,0,0,0,0, 1,'h41,1,0,0, 0, 2,1,0);
        for (int k = 0; k < 5; k++)
            add(1,0,0,1,'h42,0,1,0,0, 0,0,0,0,0, 1,'h41,1,0,0, 0, 2,1,0);
        add(1,0,0,1,'h42,0,1,1,1, 0,0,0,0,0, 1,'h42,0,0,0, 0, 2,1,0);
        add(1,0,0,1,'h43,0,1,1,1, 0,0,0,0,0, 1,'h43,0,0,0, 0, 2,1,0);
        add(1,0,1,1,'h44,1,1,1,1, 0,0,0,0,0, 1,'h44,0,1,1, 0, 2,1,0);
        add(0,0,0,0,0,0,1,1,1,    0,0,0,0,0, 0,0,0,0,0,    0, 2,2,0);
        // orphans then a valid packet
        add(1,0,0,0,'h51,0,1,1,1, 0,0,0,0,0, 0,0,0,0,0, 1, 2,2,1);
        add(1,0,0,1,'h52,0,1,1,1, 0,0,0,0,0, 0,0,0,0,0, 1, 2,2,2);
        add(1,0,1,0,'h53,0,1,1,1, 0,0,0,0,0, 0,0,0,0,0, 1, 2,2,3);
        add(0,0,0,0,0,0,1,1,1,    0,0,0,0,0, 0,0,0,0,0, 0, 2,2,3);
        add(1,1,1,0,'h61,3,1,1,1, 1,'h61,1,1,3, 0,0,0,0,0, 0, 2,2,3);
        add(0,0,0,0,0,0,1,1,1,    0,0,0,0,0, 0,0,0,0,0, 0, 3,2,3);
        // mid-packet sop truncates ch0 packet
        add(1,1,0,0,'h71,0,1,1,1, 1,'h71,1,0,0, 0,0,0,0,0, 0, 3,2,3);
        add(1,0,0,0,'h72,0,1,1,1, 1,'h72,0,0,0, 0,0,0,0,0, 0, 3,2,3);
        add(1,1,1,1,'h73,0,1,1,1, 0,0,0,0,0, 1,'h73,1,1,0, 1, 3,2,3);
        add(0,0,0,0,0,0,1,1,1,    0,0,0,0,0, 0,0,0,0,0, 0, 3,3,3);
        add(1,0,0,0,'h74,0,1,1,1, 0,0,0,0,0, 0,0,0,0,0, 1, 3,3,4);
        add(0,0,0,0,0,0,1,1,1,    0,0,0,0,0, 0,0,0,0,0, 0, 3,3,4);
        // sop in IDLE waits for both ports
        add(1,1,1,0,'h81,0,0,1,1, 1,'h81,1,1,0, 0,0,0,0,0, 0, 3,3,4);
        add(1,1,1,1,'h82,2,0,1,0, 1,'h81,1,1,0, 0,0,0,0,0, 0, 3,3,4);
        add(1,1,1,1,'h82,2,1,1,1, 0,0,0,0,0, 1,'h82,1,1,2, 0, 4,3,4);
        add(0,0,0,0,0,0,1,1,1,    0,0,0,0,0, 0,0,0,0,0, 0, 4,4,4);

        #12;
        chk_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vq[i]) begin
            vec_t t;
            string n;
            t = vq[i];
            n = $sformatf("v%0d", i);
            drive(t.v, t.s, t.e, t.ch, t.d, t.m, t.r1, t.r2);
            #1;
            chk({n, " ready"}, 32'(avsi_ready), 32'(t.xr));
            @(posedge clk);
            #1;
            chk({n, " one_valid"}, 32'(avso_one_valid), 32'(t.o1v));
            chk({n, " two_valid"}, 32'(avso_two_valid), 32'(t.o2v));
            if (t.o1v) begin
                chk({n, " one_data"}, avso_one_data, t.o1d);
                chk({n, " one_sop"}, 32'(avso_one_sop), 32'(t.o1s));
                chk({n, " one_eop"}, 32'(avso_one_eop), 32'(t.o1e));
                chk({n, " one_empty"}, 32'(avso_one_empty), 32'(t.o1m));
            end
            if (t.o2v) begin
                chk({n, " two_data"}, avso_two_data, t.o2d);
                chk({n, " two_sop"}, 32'(avso_two_sop), 32'(t.o2s));
                chk({n, " two_eop"}, 32'(avso_two_eop), 32'(t.o2e));
                chk({n, " two_empty"}, 32'(avso_two_empty), 32'(t.o2m));
            end
            chk({n, " err"}, 32'(err_pulse), 32'(t.xe));
            chk({n, " cnt_one"}, 32'(pkt_cnt_one), t.c1);
            chk({n, " cnt_two"}, 32'(pkt_cnt_two), t.c2);
            chk({n, " drop"}, 32'(drop_cnt), t.dr);
        end

        // packet counter wraps from a clean reset
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 2'd0, 1'b1, 1'b1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 17; k++)
            cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'(k));
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("wrap cnt_one", 32'(pkt_cnt_one), 32'd1);
        chk("wrap cnt_two", 32'(pkt_cnt_two), 32'd0);

        // drop counter saturates
        for (int k = 0; k < 17; k++)
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'(k));
        chk("sat err", 32'(err_pulse), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("sat drop", 32'(drop_cnt), 32'd15);
        chk("sat one_valid", 32'(avso_one_valid), 32'd0);

        // reset in the middle of a packet
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h91);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h92);
        chk("mid one_valid", 32'(avso_one_valid), 32'd1);
        chk("mid one_data", avso_one_data, 32'h92);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 2'd0, 1'b1, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("async");
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h93);
        chk("post one_valid", 32'(avso_one_valid), 32'd0);
        chk("post drop", 32'(drop_cnt), 32'd1);
        chk("post err", 32'(err_pulse), 32'd1);
        chk("post cnt_one", 32'(pkt_cnt_one), 32'd0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'hA1);
        chk("post two_valid", 32'(avso_two_valid), 32'd1);
        chk("post two_data", avso_two_data, 32'hA1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("post cnt_two", 32'(pkt_cnt_two), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/demultiplexer.md
# demultiplexer

Packet demultiplexer for the UDPMaster datapath. It takes one Avalon-ST packet stream carrying a channel field and steers each whole packet to one of two output streams. The route is chosen from the channel value on the start-of-packet beat and held until end-of-packet. The output side is registered with per-port backpressure, and the block counts delivered packets and orphan beats.

## Interface
- DATA_WIDTH, 32, width of data on input and both outputs
- EMPTY_WIDTH, 2, width of empty field
- CHANNEL_WIDTH, 1, width of channel field
- CNT_WIDTH, 16, width of packet and drop counters
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- avsi_channel / avsi_data / avsi_empty  in  CHANNEL_WIDTH / DATA_WIDTH / EMPTY_WIDTH  input beat fields
- avsi_valid / avsi_sop / avsi_eop  in  1  input beat qualifiers
- avsi_ready  out  1  input backpressure
- avso_one_channel / avso_one_data / avso_one_empty  out  as input  output one beat fields
- avso_one_valid / avso_one_sop / avso_one_eop  out  1  output one qualifiers
- avso_one_ready  in  1  output one backpressure
- avso_two_*  same set as avso_one_*  output two
- pkt_cnt_one, pkt_cnt_two  out  CNT_WIDTH  eop beats delivered per port
- drop_cnt  out  CNT_WIDTH  discarded orphan beats
- err_pulse  out  1  one-cycle protocol-error strobe

## Operation
- **Handshake:** a beat transfers on any interface when valid & ready at a rising edge. Ready latency is 0.
- **Routing:** a beat with channel == 0 targets output one. Any nonzero channel targets output two.
- **State machine:** states IDLE, PASS_ONE, PASS_TWO. Transitions happen only on accepted input beats.
  - IDLE, sop beat: the beat is routed by its channel. Next state is PASS_ONE or PASS_TWO. If the beat also has eop, next state stays IDLE.
  - IDLE, non-sop beat: orphan. It is accepted, discarded, drop_cnt increments and err_pulse fires. State stays IDLE.
  - PASS_x, non-sop beat: routed to x regardless of its channel. If eop, next state is IDLE.
  - PASS_x, sop beat: the previous packet is truncated and err_pulse fires. The beat is routed by its own channel, and next state is PASS_one/two per that channel, or IDLE if eop.
- **Per-port output register:** can_x = ~avso_x_valid | avso_x_ready.
  - An accepted beat routed to x loads all fields into x's register and sets valid.
  - If x transfers with no new load, valid clears.
  - While valid & ~ready, the registered fields hold stable.
- **avsi_ready:**
  - IDLE: can_one & can_two.
  - PASS_x: can_x & (~avsi_sop | (can_one & can_two)).
  - 0 while reset_n is low.
- **pkt_cnt_x:** +1 on each output-x transfer with eop. Wraps modulo 2^CNT_WIDTH.
- **drop_cnt:** +1 per orphan beat. Saturates at all-ones.
- **err_pulse:** high exactly one cycle after each orphan beat or mid-packet sop is accepted.

## Timing
- Reset (async assert): state IDLE. All avso_* fields and valids, counters and err_pulse are 0.
- Latency: input accept at edge N gives output valid from edge N, visible in cycle N+1.
- Throughput: 1 beat/cycle per packet when the target output is continuously ready.
- Packet switch to the other port needs no idle cycle. Beats from different packets are never interleaved on one output.
- Simultaneous load and drain on the same port in one cycle: the new beat replaces the old one and valid stays 1.
- Reset asserted mid-packet: output registers clear immediately. The truncated packet is not completed. After release, any remaining beats of that packet are orphans.
- A counter increment and a wrap in the same edge produce 0.

## Test plan
- **Basic routing:** a 4-beat packet with channel 0 (data 0x11..0x14, eop empty 2), both outputs always ready -> avso_one emits 4 beats one cycle delayed with sop/eop/empty intact. avso_two_valid stays 0 and pkt_cnt_one = 1.
- **Back-to-back switch:** a 3-beat packet on ch0 immediately followed by a 2-beat packet on ch1, no gap -> one 3-beat packet appears on one, two starts the cycle after one's last load, and pkt_cnt_one = pkt_cnt_two = 1.
- **Backpressure:** avso_two_ready held 0 for 5 cycles mid ch1 packet -> avsi_ready drops after the register fills. avso_two_data holds its value, no beat is lost or duplicated, and the packet completes after ready returns.
- **Orphans:** 3 beats with no sop in IDLE -> all are accepted, nothing is output, drop_cnt = 3, and 3 err_pulse strobes occur. A following valid packet routes normally.
- **Mid-packet sop:** ch0 sop, 1 data beat, then a ch1 sop+eop beat -> err_pulse once, output one holds 2 beats with no eop, output two holds a single sop+eop beat, state IDLE, and pkt_cnt_two = 1.
- **Counter wrap and reset:** with CNT_WIDTH = 4, send 17 single-beat ch0 packets -> pkt_cnt_one = 1. Assert reset_n mid-packet -> all outputs and counters are 0 on the same cycle.
